// File: rtl/dds_voice_sched.sv
// Multi-voice DDS scheduler: steps NUM_VOICES phase accumulators per sample tick, issues two LUT
// lookups per cycle and sums the gated samples into a signed mix word. Optional: PHASE_SYNC_EN.
module dds_voice_sched #(
   parameter int NUM_VOICES = 8,
   parameter int PHASE_W    = 32,
   parameter int LUT_AW     = 12,
   parameter int LUT_DW     = 12,
   parameter int LUT_LAT    = 3,
   localparam int MIX_W     = LUT_DW + $clog2(NUM_VOICES)
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               sample_tick,
   input  logic               cfg_wr,
   input  logic [3:0]         cfg_voice,
   input  logic [PHASE_W-1:0] cfg_inc,
   input  logic               cfg_gate,
   output logic               lut_ena,
   output logic [LUT_AW-1:0]  lut1_addr,
   output logic [LUT_AW-1:0]  lut2_addr,
   input  logic [LUT_DW-1:0]  lut1_data,
   input  logic [LUT_DW-1:0]  lut2_data,
   output logic [MIX_W-1:0]   mix_out,
   output logic               mix_valid,
   output logic               busy,
   output logic               overrun
);

   localparam int PAIRS   = NUM_VOICES / 2;
   localparam int CNT_MAX = (PAIRS > LUT_LAT) ? PAIRS : LUT_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                frame_start, frame_done, issue;

   logic [PHASE_W-1:0]  phase [NUM_VOICES];
   logic [PHASE_W-1:0]  inc   [NUM_VOICES];
   logic [PHASE_W-1:0]  sum   [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate, wr_hit, issue_hit;
`ifdef PHASE_SYNC_EN
   logic [PHASE_W-1:0]  pend_inc [NUM_VOICES];
   logic [NUM_VOICES-1:0] pend_vld, carry;
`endif

   logic                iss_g1, iss_g2;
   logic [LUT_LAT-1:0]  pl_vld, pl_g1, pl_g2;
   logic [LUT_DW-1:0]   s1, s2;
   logic [MIX_W-1:0]    add1, add2, acc;

   assign issue   = (state_q == S_ISSUE);
   assign lut_ena = issue;
   assign busy    = (state_q != S_IDLE);

   // ---------------- frame sequencer ----------------
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mix_valid <= frame_done;
         overrun   <= sample_tick && (state_q != S_IDLE);
         if (frame_done) mix_out <= acc;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sample_tick) begin
               state_d     = S_ISSUE;
               cnt_d       = '0;
               frame_start = 1'b1;
            end
         end
         S_ISSUE: begin
            if (cnt_q == CNT_W'(PAIRS - 1)) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_W'(LUT_LAT - 1)) begin
               state_d = S_OUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_OUT: begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- per-voice decode and LUT address mux ----------------
   always_comb begin
      lut1_addr = '0;
      lut2_addr = '0;
      iss_g1    = 1'b0;
      iss_g2    = 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
         wr_hit[v]    = cfg_wr && (32'(cfg_voice) == v);
         issue_hit[v] = issue && ((v >> 1) == 32'(cnt_q));
`ifdef PHASE_SYNC_EN
         {carry[v], sum[v]} = {1'b0, phase[v]} + {1'b0, inc[v]};
`else
         sum[v] = phase[v] + inc[v];
`endif
         if (issue_hit[v]) begin
            if ((v % 2) == 0) begin
               lut1_addr = phase[v][PHASE_W-1 -: LUT_AW];
               iss_g1    = gate[v];
            end else begin
               lut2_addr = phase[v][PHASE_W-1 -: LUT_AW];
               iss_g2    = gate[v];
            end
         end
      end
   end

   // ---------------- voice state ----------------
   // A gate 0->1 write zeroes the phase and wins over a same-cycle issue increment.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gate <= '0;
`ifdef PHASE_SYNC_EN
         pend_vld <= '0;
`endif
         for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            phase[v] <= '0;
            inc[v]   <= '0;
`ifdef PHASE_SYNC_EN
            pend_inc[v] <= '0;
`endif
         end
      end else begin
         for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (wr_hit[v]) gate[v] <= cfg_gate;

            if (wr_hit[v] && cfg_gate && !gate[v]) phase[v] <= '0;
            else if (issue_hit[v])                  phase[v] <= sum[v];

`ifdef PHASE_SYNC_EN
            // Silent voices take a new step at once; sounding ones wait for the phase wrap.
            if (wr_hit[v]) begin
               if (!cfg_gate || !gate[v]) begin
                  inc[v]      <= cfg_inc;
                  pend_vld[v] <= 1'b0;
               end else begin
                  pend_inc[v] <= cfg_inc;
                  pend_vld[v] <= 1'b1;
               end
            end else if (pend_vld[v] && (!gate[v] || (issue_hit[v] && carry[v]))) begin
               inc[v]      <= pend_inc[v];
               pend_vld[v] <= 1'b0;
            end
`else
            if (wr_hit[v]) inc[v] <= cfg_inc;
`endif
         end
      end
   end

   // ---------------- capture pipeline and accumulator ----------------
   assign s1   = {~lut1_data[LUT_DW-1], lut1_data[LUT_DW-2:0]};
   assign s2   = {~lut2_data[LUT_DW-1], lut2_data[LUT_DW-2:0]};
   assign add1 = pl_g1[LUT_LAT-1] ? {{(MIX_W-LUT_DW){s1[LUT_DW-1]}}, s1} : '0;
   assign add2 = pl_g2[LUT_LAT-1] ? {{(MIX_W-LUT_DW){s2[LUT_DW-1]}}, s2} : '0;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pl_vld <= '0;
         pl_g1  <= '0;
         pl_g2  <= '0;
         acc    <= '0;
      end else begin
         pl_vld[0] <= issue;
         pl_g1[0]  <= iss_g1;
         pl_g2[0]  <= iss_g2;
         for (int unsigned i = 1; i < LUT_LAT; i++) begin
            pl_vld[i] <= pl_vld[i-1];
            pl_g1[i]  <= pl_g1[i-1];
            pl_g2[i]  <= pl_g2[i-1];
         end
         if (frame_start)              acc <= '0;
         else if (pl_vld[LUT_LAT-1])   acc <= acc + add1 + add2;
      end
   end

endmodule

// File: tb/tb_dds_voice_sched.sv
// Directed self-checking bench for dds_voice_sched with a LUT_LAT-deep echo/constant LUT model.
module tb_dds_voice_sched;

   localparam int NV = 8, PW = 32, AW = 12, DW = 12, LAT = 3, MW = 15;

   logic           sys_clk = 1'b0;
   logic           sys_rst = 1'b0;
   logic           sample_tick = 1'b0;
   logic           cfg_wr = 1'b0;
   logic [3:0]     cfg_voice = '0;
   logic [PW-1:0]  cfg_inc = '0;
   logic           cfg_gate = 1'b0;
   logic           lut_ena;
   logic [AW-1:0]  lut1_addr, lut2_addr;
   logic [DW-1:0]  lut1_data, lut2_data;
   logic [MW-1:0]  mix_out;
   logic           mix_valid, busy, overrun;

   dds_voice_sched #(
      .NUM_VOICES(NV), .PHASE_W(PW), .LUT_AW(AW), .LUT_DW(DW), .LUT_LAT(LAT)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_tick(sample_tick),
      .cfg_wr(cfg_wr), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc), .cfg_gate(cfg_gate),
      .lut_ena(lut_ena), .lut1_addr(lut1_addr), .lut2_addr(lut2_addr),
      .lut1_data(lut1_data), .lut2_data(lut2_data),
      .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
   );

   always #5 sys_clk = ~sys_clk;

   // LUT model: data appears LAT cycles after the address, either echoed or a constant.
   logic          lut_const_en = 1'b0;
   logic [DW-1:0] lut_const = '0;
   logic [DW-1:0] p1 [LAT];
   logic [DW-1:0] p2 [LAT];
   always @(posedge sys_clk) begin
      p1[0] <= lut_const_en ? lut_const : lut1_addr;
      p2[0] <= lut_const_en ? lut_const : lut2_addr;
      for (int i = 1; i < LAT; i++) begin
         p1[i] <= p1[i-1];
         p2[i] <= p2[i-1];
      end
   end
   assign lut1_data = p1[LAT-1];
   assign lut2_data = p2[LAT-1];

   int ntests = 0;
   int nfail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_cfg(input logic [3:0] v, input logic [PW-1:0] inc, input logic g);
      @(negedge sys_clk);
      cfg_wr = 1'b1; cfg_voice = v; cfg_inc = inc; cfg_gate = g;
      @(negedge sys_clk);
      cfg_wr = 1'b0;
   endtask

   // Frame runner: cycle c of the frame is sampled mid-cycle; tick is cycle 0.
   int            wa_cyc = -1, wb_cyc = -1, t2_cyc = -1;
   logic [3:0]    wa_voice, wb_voice;
   logic [PW-1:0] wa_inc, wb_inc;
   logic          wa_gate, wb_gate;
   logic [AW-1:0] fa1 [1:4];
   logic [AW-1:0] fa2 [1:4];
   logic          fena [1:4];
   int            f_lat, f_nvalid, f_ovcnt, f_ovcyc;
   logic [MW-1:0] f_mix;

   task automatic run_frame();
      f_lat = 0; f_nvalid = 0; f_ovcnt = 0; f_ovcyc = 0; f_mix = '0;
      @(negedge sys_clk);
      sample_tick = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge sys_clk);
         sample_tick = (c == t2_cyc);
         if (c == wa_cyc) begin
            cfg_wr = 1'b1; cfg_voice = wa_voice; cfg_inc = wa_inc; cfg_gate = wa_gate;
         end else if (c == wb_cyc) begin
            cfg_wr = 1'b1; cfg_voice = wb_voice; cfg_inc = wb_inc; cfg_gate = wb_gate;
         end else begin
            cfg_wr = 1'b0;
         end
         if (c <= 4) begin
            fa1[c] = lut1_addr; fa2[c] = lut2_addr; fena[c] = lut_ena;
         end
         if (overrun) begin
            f_ovcnt++; f_ovcyc = c;
         end
         if (mix_valid) begin
            f_nvalid++;
            if (f_lat == 0) begin
               f_lat = c; f_mix = mix_out;
            end
         end
      end
      sample_tick = 1'b0; cfg_wr = 1'b0;
      wa_cyc = -1; wb_cyc = -1; t2_cyc = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;

      // Reset state
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      chk("rst_mix_out", mix_out, 0);
      chk("rst_mix_valid", mix_valid, 0);
      chk("rst_lut_ena", lut_ena, 0);
      chk("rst_lut1_addr", lut1_addr, 0);
      chk("rst_lut2_addr", lut2_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      sys_rst = 1'b0;

      // 1: single voice, echo LUT, address steps by one per tick
      do_cfg(4'd0, 32'h0010_0000, 1'b1);
      for (int k = 0; k < 3; k++) begin
         run_frame();
         chk("t1_addr_v0", fa1[1], k);
         chk("t1_latency", f_lat, 9);
         chk("t1_mix", f_mix, 15'h7800 + k);
         chk("t1_npulse", f_nvalid, 1);
      end
      chk("t1_ena_issue", fena[1], 1);
      chk("t1_busy_after", busy, 0);
      chk("t1_ena_after", lut_ena, 0);

      // 2: all voices gated, full-scale positive and negative
      for (int v = 1; v < NV; v++) do_cfg(4'(v), 32'h0, 1'b1);
      lut_const_en = 1'b1;
      lut_const    = 12'hFFF;
      run_frame();
      chk("t2_mix_pos", f_mix, 15'h3FF8);
      lut_const = 12'h000;
      run_frame();
      chk("t2_mix_neg", f_mix, 15'h4000);

      // 3: second tick 3 cycles after the first
      t2_cyc = 3;
      run_frame();
      chk("t3_ov_count", f_ovcnt, 1);
      chk("t3_ov_cycle", f_ovcyc, 4);
      chk("t3_npulse", f_nvalid, 1);
      chk("t3_latency", f_lat, 9);
      chk("t3_mix", f_mix, 15'h4000);
      lut_const = 12'hFFF;
      run_frame();
      chk("t3_next_latency", f_lat, 9);
      chk("t3_next_mix", f_mix, 15'h3FF8);
      chk("t3_next_ov", f_ovcnt, 0);

      // 4: reset during DRAIN aborts the frame
      @(negedge sys_clk);
      sample_tick = 1'b1;
      @(negedge sys_clk);
      sample_tick = 1'b0;
      repeat (5) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      chk("t4_rst_mix_out", mix_out, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_ena", lut_ena, 0);
      chk("t4_rst_valid", mix_valid, 0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge sys_clk);
         if (mix_valid) nv++;
      end
      chk("t4_no_valid", nv, 0);
      lut_const_en = 1'b0;
      run_frame();
      chk("t4_addr_v0", fa1[1], 0);
      chk("t4_latency", f_lat, 9);
      chk("t4_mix", f_mix, 0);

      // 5: mid-frame writes to voice7 (not yet issued) and voice0 (already issued)
      do_cfg(4'd0, 32'h0010_0000, 1'b1);
      wa_cyc = 2; wa_voice = 4'd7; wa_inc = 32'h0020_0000; wa_gate = 1'b1;
      wb_cyc = 3; wb_voice = 4'd0; wb_inc = 32'h0030_0000; wb_gate = 1'b0;
      run_frame();
      chk("t5a_addr_v0", fa1[1], 0);
      chk("t5a_addr_v7", fa2[4], 0);
      chk("t5a_mix", f_mix, 15'h7000);
      run_frame();
      chk("t5b_addr_v0", fa1[1], 1);
      chk("t5b_addr_v7", fa2[4], 2);
      chk("t5b_mix", f_mix, 15'h7802);
      do_cfg(4'd9, 32'h0050_0000, 1'b1);
      run_frame();
      chk("t5c_addr_v0", fa1[1], 4);
      chk("t5c_addr_v7", fa2[4], 4);
      chk("t5c_addr_v1", fa2[1], 0);
      chk("t5c_mix", f_mix, 15'h7804);

`ifdef PHASE_SYNC_EN
      // 6: pending increment is applied only at the phase wrap
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      do_cfg(4'd0, 32'h4000_0000, 1'b1);
      run_frame();
      chk("t6_addr_f1", fa1[1], 12'h000);
      run_frame();
      chk("t6_addr_f2", fa1[1], 12'h400);
      do_cfg(4'd0, 32'h1000_0000, 1'b1);
      run_frame();
      chk("t6_addr_f3", fa1[1], 12'h800);
      run_frame();
      chk("t6_addr_f4", fa1[1], 12'hC00);
      run_frame();
      chk("t6_addr_f5", fa1[1], 12'h000);
      run_frame();
      chk("t6_addr_f6", fa1[1], 12'h100);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
